down_timer: RTL

Loadable one-shot/periodic down-counter timer. It complements the free-running up-counter: instead of counting up from reset, it loads a period, counts down to zero under an enable, and flags expiry with a one-cycle `tick`. It sits beside the up-counter in the timing/sequencing logic and serves as the countdown source for delays, timeouts and periodic events.

---
 rtl/down_timer.sv | 94 +++++++++
 1 files changed

// File: rtl/down_timer.sv
// Loadable one-shot/periodic down-counter timer with a one-cycle expiry tick.
// Optional periodic mode is enabled by defining DOWN_TIMER_AUTORELOAD_EN.
module down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] period_i,
`ifdef DOWN_TIMER_AUTORELOAD_EN
   input  logic             reload_i,
`endif
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             tick_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             tick_q, tick_d;
   logic             reload_act;

`ifdef DOWN_TIMER_AUTORELOAD_EN
   assign reload_act = reload_i;
`else
   assign reload_act = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         count_q  <= '0;
         shadow_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         tick_q   <= tick_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a value unassigned and no latch can be inferred.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      shadow_d = shadow_q;
      tick_d   = 1'b0;

      if (stop_i) begin
         state_d = IDLE;
         count_d = '0;
      end else if (start_i) begin
         shadow_d = period_i;
         if (period_i != '0) begin
            state_d = RUN;
            count_d = period_i;
         end else begin
            state_d = IDLE;
            count_d = '0;
            tick_d  = 1'b1;
         end
      end else if (state_q == RUN && en_i) begin
         // In RUN the count is always at least 1, so this is the expiry edge.
         if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
         end else begin
            tick_d = 1'b1;
            if (reload_act) begin
               count_d = shadow_q;
            end else begin
               state_d = IDLE;
               count_d = '0;
            end
         end
      end
   end

   assign count_o = count_q;
   assign busy_o  = (state_q == RUN);
   assign tick_o  = tick_q;

endmodule
